vga_vram_arbiter: RTL and testbench

- Shares one single-port text VRAM (600 character words plus the control word at 600) between two requesters:
  - the Avalon-MM slave port (CPU read/write with byte enables);
  - the display glyph-fetch engine (read-only).
- Sits between the Avalon fabric, the pixel pipeline and the RAM macro; it replaces direct register-array access.
- Display fetches have priority. A starvation counter guarantees the CPU forward progress.

---
 rtl/vga_vram_arbiter.sv | 123 ++++++++++++
 tb/tb_vga_vram_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_vram_arbiter.sv
// Arbitrates one single-port text VRAM between the Avalon-MM slave and the
// display glyph fetcher; display has priority, a starvation counter bounds CPU delay.
module vga_vram_arbiter #(
    parameter int ADDR_W   = 10,
    parameter int DEPTH    = 601,
    parameter int MAX_WAIT = 4
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              AVL_CS,
    input  logic              AVL_READ,
    input  logic              AVL_WRITE,
    input  logic [3:0]        AVL_BYTE_EN,
    input  logic [ADDR_W-1:0] AVL_ADDR,
    input  logic [31:0]       AVL_WRITEDATA,
    output logic [31:0]       AVL_READDATA,
    output logic              AVL_WAITREQUEST,
    input  logic              DISP_REQ,
    input  logic [ADDR_W-1:0] DISP_ADDR,
    output logic              DISP_ACK,
    output logic              DISP_VALID,
    output logic [31:0]       DISP_DATA,
    output logic [ADDR_W-1:0] RAM_ADDR,
    output logic              RAM_WE,
    output logic [3:0]        RAM_BE,
    output logic [31:0]       RAM_WDATA,
    input  logic [31:0]       RAM_RDATA
);

    localparam int ST_W = $clog2(MAX_WAIT + 1);
    localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ST_W-1:0]   STARVE_MAX = ST_W'(MAX_WAIT);

    typedef enum logic {IDLE, RD_RET} state_t;

    state_t          r_state;
    logic [ST_W-1:0] r_starve;
    logic            r_rd_done;
    logic            r_avl_oor;
    logic            r_disp_oor;
    logic            r_disp_valid;
    logic [31:0]     r_rdata;

    logic w_avl_req;
    logic w_avl_p;
    logic w_starved;
    logic w_grant_avl;
    logic w_grant_disp;
    logic w_avl_in;
    logic w_disp_in;
    logic w_completing;

    assign w_avl_req = AVL_CS & (AVL_READ | AVL_WRITE);
    // The cycle after RD_RET hands back read data; it must not start a new access.
    assign w_avl_p   = w_avl_req & (r_state == IDLE) & ~r_rd_done;
    assign w_starved = (r_starve == STARVE_MAX);
    assign w_avl_in  = ({1'b0, AVL_ADDR}  < DEPTH_C);
    assign w_disp_in = ({1'b0, DISP_ADDR} < DEPTH_C);

    assign w_grant_avl  = RESET_N & w_avl_p & (~DISP_REQ | w_starved);
    assign w_grant_disp = RESET_N & DISP_REQ & ~w_grant_avl;

    assign w_completing    = (w_grant_avl & AVL_WRITE) | r_rd_done;
    assign AVL_WAITREQUEST = ~RESET_N | (w_avl_req & ~w_completing);
    assign AVL_READDATA    = r_rdata;
    assign DISP_ACK        = w_grant_disp;
    assign DISP_VALID      = r_disp_valid;
    assign DISP_DATA       = r_disp_oor ? '0 : RAM_RDATA;

    always_comb begin
        RAM_ADDR  = '0;
        RAM_WE    = 1'b0;
        RAM_BE    = '0;
        RAM_WDATA = AVL_WRITEDATA;
        if (w_grant_avl && w_avl_in) begin
            RAM_ADDR = AVL_ADDR;
            if (AVL_WRITE) begin
                RAM_WE = 1'b1;
                RAM_BE = AVL_BYTE_EN;
            end
        end else if (w_grant_disp && w_disp_in) begin
            RAM_ADDR = DISP_ADDR;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state      <= IDLE;
            r_starve     <= '0;
            r_rd_done    <= 1'b0;
            r_avl_oor    <= 1'b0;
            r_disp_oor   <= 1'b0;
            r_disp_valid <= 1'b0;
            r_rdata      <= '0;
        end else begin
            r_rd_done    <= 1'b0;
            r_disp_valid <= w_grant_disp;
            r_disp_oor   <= ~w_disp_in;

            if (w_grant_avl) begin
                r_starve <= '0;
            end else if (w_avl_p && !w_starved) begin
                r_starve <= r_starve + 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (w_grant_avl && !AVL_WRITE) begin
                        r_state   <= RD_RET;
                        r_avl_oor <= ~w_avl_in;
                    end
                end
                RD_RET: begin
                    r_rdata   <= r_avl_oor ? '0 : RAM_RDATA;
                    r_rd_done <= 1'b1;
                    r_state   <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_vram_arbiter.sv
// Self-checking bench for vga_vram_arbiter: directed vector table, hand-written
// starvation/reset sequences, then random traffic against a transaction-level model.
module tb_vga_vram_arbiter;

    localparam int ADDR_W   = 10;
    localparam int DEPTH    = 601;
    localparam int MAX_WAIT = 4;

    logic              CLK = 1'b0;
    logic              RESET_N;
    logic              AVL_CS, AVL_READ, AVL_WRITE;
    logic [3:0]        AVL_BYTE_EN;
    logic [ADDR_W-1:0] AVL_ADDR;
    logic [31:0]       AVL_WRITEDATA;
    logic [31:0]       AVL_READDATA;
    logic              AVL_WAITREQUEST;
    logic              DISP_REQ;
    logic [ADDR_W-1:0] DISP_ADDR;
    logic              DISP_ACK, DISP_VALID;
    logic [31:0]       DISP_DATA;
    logic [ADDR_W-1:0] RAM_ADDR;
    logic              RAM_WE;
    logic [3:0]        RAM_BE;
    logic [31:0]       RAM_WDATA;
    logic [31:0]       RAM_RDATA;

    always #10 CLK = ~CLK;

    vga_vram_arbiter #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .AVL_CS(AVL_CS), .AVL_READ(AVL_READ), .AVL_WRITE(AVL_WRITE),
        .AVL_BYTE_EN(AVL_BYTE_EN), .AVL_ADDR(AVL_ADDR), .AVL_WRITEDATA(AVL_WRITEDATA),
        .AVL_READDATA(AVL_READDATA), .AVL_WAITREQUEST(AVL_WAITREQUEST),
        .DISP_REQ(DISP_REQ), .DISP_ADDR(DISP_ADDR), .DISP_ACK(DISP_ACK),
        .DISP_VALID(DISP_VALID), .DISP_DATA(DISP_DATA),
        .RAM_ADDR(RAM_ADDR), .RAM_WE(RAM_WE), .RAM_BE(RAM_BE),
        .RAM_WDATA(RAM_WDATA), .RAM_RDATA(RAM_RDATA)
    );

    // RAM macro model: byte-enabled write, one-cycle read latency
    logic [31:0] mem [0:1023];
    initial for (int i = 0; i < 1024; i++) mem[i] <= 32'hA500_0000 | 32'(i);
    always @(posedge CLK) begin
        if (RAM_WE)
            for (int b = 0; b < 4; b++)
                if (RAM_BE[b]) mem[RAM_ADDR][8*b +: 8] <= RAM_WDATA[8*b +: 8];
        RAM_RDATA <= mem[RAM_ADDR];
    end

    // Expected RAM contents, updated when the model decides a write has landed
    logic [31:0] shadow [0:1023];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    typedef struct {
        logic        cs, rd, wr;
        logic [3:0]  be;
        logic [9:0]  addr;
        logic [31:0] wd;
        logic        dreq;
        logic [9:0]  daddr;
        logic        e_wait, e_we, e_ack, e_val;
        logic [9:0]  e_raddr;
        logic        chk_rd;
        logic [31:0] e_rdata;
        logic        chk_dd;
        logic [31:0] e_ddata;
    } vec_t;

    function automatic vec_t mk(input logic cs, rd, wr, input logic [3:0] be,
                                input logic [9:0] addr, input logic [31:0] wd,
                                input logic dreq, input logic [9:0] daddr,
                                input logic e_wait, e_we, e_ack, e_val,
                                input logic [9:0] e_raddr,
                                input logic chk_rd, input logic [31:0] e_rdata,
                                input logic chk_dd, input logic [31:0] e_ddata);
        vec_t v;
        v.cs = cs; v.rd = rd; v.wr = wr; v.be = be; v.addr = addr; v.wd = wd;
        v.dreq = dreq; v.daddr = daddr;
        v.e_wait = e_wait; v.e_we = e_we; v.e_ack = e_ack; v.e_val = e_val;
        v.e_raddr = e_raddr; v.chk_rd = chk_rd; v.e_rdata = e_rdata;
        v.chk_dd = chk_dd; v.e_ddata = e_ddata;
        return v;
    endfunction

    task automatic drive_avl(input logic cs, rd, wr, input logic [3:0] be,
                             input logic [9:0] a, input logic [31:0] d);
        AVL_CS = cs; AVL_READ = rd; AVL_WRITE = wr;
        AVL_BYTE_EN = be; AVL_ADDR = a; AVL_WRITEDATA = d;
    endtask

    // Display held on continuously; CPU write must lose exactly MAX_WAIT times
    task automatic starve_write(input logic [9:0] a, input logic [31:0] d);
        for (int k = 1; k <= MAX_WAIT + 1; k++) begin
            @(posedge CLK); #1;
            drive_avl(1'b1, 1'b0, 1'b1, 4'hF, a, d);
            DISP_REQ = 1'b1; DISP_ADDR = 10'd1;
            @(negedge CLK);
            if (k <= MAX_WAIT) begin
                check($sformatf("starve_ack_%0d", k), 32'(DISP_ACK), 32'd1);
                check($sformatf("starve_we_%0d", k), 32'(RAM_WE), 32'd0);
                check($sformatf("starve_wait_%0d", k), 32'(AVL_WAITREQUEST), 32'd1);
            end else begin
                check("starve_force_ack", 32'(DISP_ACK), 32'd0);
                check("starve_force_we", 32'(RAM_WE), 32'd1);
                check("starve_force_wait", 32'(AVL_WAITREQUEST), 32'd0);
                check("starve_force_addr", 32'(RAM_ADDR), 32'(a));
            end
        end
        shadow[a] = d;
        @(posedge CLK); #1;
        AVL_CS = 1'b0;
        @(negedge CLK);
        check("starve_disp_again", 32'(DISP_ACK), 32'd1);
    endtask

    vec_t vecs[27];

    // random-phase model state
    logic        cpu_active, cpu_wr, cpu_dreq0;
    logic [9:0]  cpu_addr;
    logic [3:0]  cpu_be;
    logic [31:0] cpu_data;
    int          cpu_lat;
    logic        disp_active, prev_ack;
    logic [9:0]  disp_addr;
    logic [31:0] disp_q[$];
    logic [31:0] exp_d;
    int          lat;

    initial begin
        #(20 * 60000);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 1024; i++) shadow[i] = 32'hA500_0000 | 32'(i);

        //            cs rd wr be    addr    wdata          dq daddr   wt we ak vl raddr   crd rdata          cdd ddata
        vecs[0]  = mk(0, 0, 0, 4'h0, 10'd0,   32'h0,         0, 10'd0,   0, 0, 0, 0, 10'd0,   0, 32'h0,         0, 32'h0);
        vecs[1]  = mk(1, 0, 1, 4'hF, 10'd5,   32'h41424344,  0, 10'd0,   0, 1, 0, 0, 10'd5,   0, 32'h0,         0, 32'h0);
        vecs[2]  = mk(1, 1, 0, 4'hF, 10'd5,   32'h0,         0, 10'd0,   1, 0, 0, 0, 10'd5,   0, 32'h0,         0, 32'h0);
        vecs[3]  = mk(1, 1, 0, 4'hF, 10'd5,   32'h0,         0, 10'd0,   1, 0, 0, 0, 10'd0,   0, 32'h0,         0, 32'h0);
        vecs[4]  = mk(1, 1, 0, 4'hF, 10'd5,   32'h0,         0, 10'd0,   0, 0, 0, 0, 10'd0,   1, 32'h41424344,  0, 32'h0);
        vecs[5]  = mk(0, 0, 0, 4'h0, 10'd0,   32'h0,         0, 10'd0,   0, 0, 0, 0, 10'd0,   0, 32'h0,         0, 32'h0);
        vecs[6]  = mk(1, 0, 1, 4'h4, 10'd5,   32'hFFFFFFFF,  0, 10'd0,   0, 1, 0, 0, 10'd5,   0, 32'h0,         0, 32'h0);
        vecs[7]  = mk(1, 1, 0, 4'hF, 10'd5,   32'h0,         0, 10'd0,   1, 0, 0, 0, 10'd5,   0, 32'h0,         0, 32'h0);
        vecs[8]  = mk(1, 1, 0, 4'hF, 10'd5,   32'h0,         0, 10'd0,   1, 0, 0, 0, 10'd0,   0, 32'h0,         0, 32'h0);
        vecs[9]  = mk(1, 1, 0, 4'hF, 10'd5,   32'h0,         0, 10'd0,   0, 0, 0, 0, 10'd0,   1, 32'h41FF4344,  0, 32'h0);
        vecs[10] = mk(1, 1, 0, 4'hF, 10'd600, 32'h0,         0, 10'd0,   1, 0, 0, 0, 10'd600, 0, 32'h0,         0, 32'h0);
        vecs[11] = mk(1, 1, 0, 4'hF, 10'd600, 32'h0,         1, 10'd3,   1, 0, 1, 0, 10'd3,   0, 32'h0,         0, 32'h0);
        vecs[12] = mk(1, 1, 0, 4'hF, 10'd600, 32'h0,         0, 10'd0,   0, 0, 0, 1, 10'd0,   1, 32'hA5000258,  1, 32'hA5000003);
        vecs[13] = mk(0, 0, 0, 4'h0, 10'd0,   32'h0,         0, 10'd0,   0, 0, 0, 0, 10'd0,   0, 32'h0,         0, 32'h0);
        vecs[14] = mk(1, 0, 1, 4'hF, 10'd700, 32'h11111111,  0, 10'd0,   0, 0, 0, 0, 10'd0,   0, 32'h0,         0, 32'h0);
        vecs[15] = mk(1, 1, 0, 4'hF, 10'd700, 32'h0,         0, 10'd0,   1, 0, 0, 0, 10'd0,   0, 32'h0,         0, 32'h0);
        vecs[16] = mk(1, 1, 0, 4'hF, 10'd700, 32'h0,         0, 10'd0,   1, 0, 0, 0, 10'd0,   0, 32'h0,         0, 32'h0);
        vecs[17] = mk(1, 1, 0, 4'hF, 10'd700, 32'h0,         0, 10'd0,   0, 0, 0, 0, 10'd0,   1, 32'h0,         0, 32'h0);
        vecs[18] = mk(0, 0, 0, 4'h0, 10'd0,   32'h0,         1, 10'd650, 0, 0, 1, 0, 10'd0,   0, 32'h0,         0, 32'h0);
        vecs[19] = mk(0, 0, 0, 4'h0, 10'd0,   32'h0,         0, 10'd0,   0, 0, 0, 1, 10'd0,   0, 32'h0,         1, 32'h0);
        vecs[20] = mk(1, 0, 1, 4'hF, 10'd7,   32'h12345678,  1, 10'd2,   1, 0, 1, 0, 10'd2,   0, 32'h0,         0, 32'h0);
        vecs[21] = mk(1, 0, 1, 4'hF, 10'd7,   32'h12345678,  0, 10'd0,   0, 1, 0, 1, 10'd7,   0, 32'h0,         1, 32'hA5000002);
        vecs[22] = mk(1, 1, 0, 4'hF, 10'd7,   32'h0,         1, 10'd7,   1, 0, 1, 0, 10'd7,   0, 32'h0,         0, 32'h0);
        vecs[23] = mk(1, 1, 0, 4'hF, 10'd7,   32'h0,         0, 10'd0,   1, 0, 0, 1, 10'd7,   0, 32'h0,         1, 32'h12345678);
        vecs[24] = mk(1, 1, 0, 4'hF, 10'd7,   32'h0,         0, 10'd0,   1, 0, 0, 0, 10'd0,   0, 32'h0,         0, 32'h0);
        vecs[25] = mk(1, 1, 0, 4'hF, 10'd7,   32'h0,         0, 10'd0,   0, 0, 0, 0, 10'd0,   1, 32'h12345678,  0, 32'h0);
        vecs[26] = mk(0, 0, 0, 4'h0, 10'd0,   32'h0,         0, 10'd0,   0, 0, 0, 0, 10'd0,   0, 32'h0,         0, 32'h0);

        RESET_N = 1'b0;
        drive_avl(1'b0, 1'b0, 1'b0, 4'h0, 10'd0, 32'h0);
        DISP_REQ = 1'b0; DISP_ADDR = '0;
        repeat (2) @(negedge CLK);
        check("rst_wait", 32'(AVL_WAITREQUEST), 32'd1);
        check("rst_rdata", AVL_READDATA, 32'h0);
        check("rst_valid", 32'(DISP_VALID), 32'd0);
        check("rst_ack", 32'(DISP_ACK), 32'd0);
        check("rst_we", 32'(RAM_WE), 32'd0);
        RESET_N = 1'b1;

        for (int i = 0; i < 27; i++) begin
            @(posedge CLK); #1;
            drive_avl(vecs[i].cs, vecs[i].rd, vecs[i].wr, vecs[i].be, vecs[i].addr, vecs[i].wd);
            DISP_REQ = vecs[i].dreq; DISP_ADDR = vecs[i].daddr;
            @(negedge CLK);
            check($sformatf("v%0d_wait", i), 32'(AVL_WAITREQUEST), 32'(vecs[i].e_wait));
            check($sformatf("v%0d_we", i), 32'(RAM_WE), 32'(vecs[i].e_we));
            check($sformatf("v%0d_ack", i), 32'(DISP_ACK), 32'(vecs[i].e_ack));
            check($sformatf("v%0d_valid", i), 32'(DISP_VALID), 32'(vecs[i].e_val));
            check($sformatf("v%0d_raddr", i), 32'(RAM_ADDR), 32'(vecs[i].e_raddr));
            if (vecs[i].chk_rd) check($sformatf("v%0d_rdata", i), AVL_READDATA, vecs[i].e_rdata);
            if (vecs[i].chk_dd) check($sformatf("v%0d_ddata", i), DISP_DATA, vecs[i].e_ddata);
        end
        shadow[5] = 32'h41FF4344;
        shadow[7] = 32'h12345678;

        starve_write(10'd10, 32'hDEADBEEF);
        starve_write(10'd11, 32'hCAFEF00D);

        // Reset asserted while a read sits in RD_RET
        @(posedge CLK); #1;
        drive_avl(1'b1, 1'b1, 1'b0, 4'hF, 10'd5, 32'h0);
        DISP_REQ = 1'b0;
        @(negedge CLK);
        check("rr_grant_wait", 32'(AVL_WAITREQUEST), 32'd1);
        @(posedge CLK); #1;
        DISP_REQ = 1'b1; DISP_ADDR = 10'd4;
        #5;
        RESET_N = 1'b0;
        #1;
        check("rr_wait", 32'(AVL_WAITREQUEST), 32'd1);
        check("rr_we", 32'(RAM_WE), 32'd0);
        check("rr_ack", 32'(DISP_ACK), 32'd0);
        check("rr_valid", 32'(DISP_VALID), 32'd0);
        check("rr_rdata", AVL_READDATA, 32'h0);
        @(negedge CLK);
        check("rr_valid_held", 32'(DISP_VALID), 32'd0);
        check("rr_wait_held", 32'(AVL_WAITREQUEST), 32'd1);
        @(posedge CLK); #1;
        RESET_N = 1'b1;
        DISP_REQ = 1'b0;
        lat = 0;
        while (lat < 10) begin
            if (lat > 0) begin @(posedge CLK); #1; end
            @(negedge CLK);
            lat++;
            if (!AVL_WAITREQUEST) break;
        end
        check("rr_reissue_lat", 32'(lat), 32'd3);
        check("rr_reissue_data", AVL_READDATA, 32'h41FF4344);
        @(posedge CLK); #1;
        AVL_CS = 1'b0;
        @(negedge CLK);
        prev_ack = DISP_ACK;

        // Random traffic against the transaction-level model
        cpu_active = 1'b0; disp_active = 1'b0;
        cpu_wr = 1'b0; cpu_dreq0 = 1'b0; cpu_addr = '0; cpu_be = '0; cpu_data = '0;
        cpu_lat = 0; disp_addr = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge CLK); #1;
            if (!cpu_active) begin
                if ($urandom_range(0, 2) == 0) begin
                    cpu_active = 1'b1;
                    cpu_wr   = 1'($urandom_range(0, 1));
                    cpu_addr = ($urandom_range(0, 9) == 0) ? 10'($urandom_range(DEPTH, 1023))
                                                           : 10'($urandom_range(0, DEPTH - 1));
                    cpu_be   = 4'($urandom);
                    cpu_data = $urandom;
                    cpu_lat  = 0;
                    drive_avl(1'b1, cpu_wr ? ($urandom_range(0, 3) == 0) : 1'b1, cpu_wr,
                              cpu_be, cpu_addr, cpu_data);
                end else begin
                    drive_avl(1'b0, 1'($urandom), 1'($urandom), 4'($urandom), 10'($urandom), $urandom);
                end
            end
            if (!disp_active && $urandom_range(0, 3) != 0) begin
                disp_active = 1'b1;
                disp_addr = ($urandom_range(0, 9) == 0) ? 10'($urandom_range(DEPTH, 1023))
                                                        : 10'($urandom_range(0, DEPTH - 1));
            end
            DISP_REQ = disp_active; DISP_ADDR = disp_addr;

            @(negedge CLK);
            check("rnd_exclusive", 32'(DISP_ACK & RAM_WE), 32'd0);
            if (cpu_active) begin
                cpu_lat++;
                if (cpu_lat == 1) cpu_dreq0 = ~DISP_REQ;
                if (!AVL_WAITREQUEST) begin
                    if (cpu_wr) begin
                        if (cpu_addr < DEPTH) begin
                            check("rnd_wr_we", 32'(RAM_WE), 32'd1);
                            check("rnd_wr_addr", 32'(RAM_ADDR), 32'(cpu_addr));
                            check("rnd_wr_be", 32'(RAM_BE), 32'(cpu_be));
                            for (int b = 0; b < 4; b++)
                                if (cpu_be[b]) shadow[cpu_addr][8*b +: 8] = cpu_data[8*b +: 8];
                        end else begin
                            check("rnd_wr_oor_we", 32'(RAM_WE), 32'd0);
                        end
                        if (cpu_dreq0) check("rnd_wr_lat", 32'(cpu_lat), 32'd1);
                        else check("rnd_wr_lat_bound", 32'(cpu_lat <= MAX_WAIT + 1), 32'd1);
                    end else begin
                        check("rnd_rd_data", AVL_READDATA,
                              (cpu_addr < DEPTH) ? shadow[cpu_addr] : 32'h0);
                        if (cpu_dreq0) check("rnd_rd_lat", 32'(cpu_lat), 32'd3);
                        else check("rnd_rd_lat_bound",
                                   32'(cpu_lat >= 3 && cpu_lat <= MAX_WAIT + 3), 32'd1);
                    end
                    cpu_active = 1'b0;
                end else if (cpu_lat > 20) begin
                    check("rnd_cpu_timeout", 32'(cpu_lat), 32'(MAX_WAIT + 3));
                    cpu_active = 1'b0;
                end
            end
            check("rnd_valid", 32'(DISP_VALID), 32'(prev_ack));
            if (DISP_VALID) begin
                if (disp_q.size() == 0) begin
                    check("rnd_disp_unexpected", 32'(DISP_VALID), 32'd0);
                end else begin
                    exp_d = disp_q.pop_front();
                    check("rnd_disp_data", DISP_DATA, exp_d);
                end
            end
            prev_ack = DISP_ACK;
            if (DISP_ACK) begin
                check("rnd_ack_req", 32'(disp_active), 32'd1);
                disp_q.push_back((disp_addr < DEPTH) ? shadow[disp_addr] : 32'h0);
                disp_active = 1'b0;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
